// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline interlock controller.
//   hz_state_t : controller state encoding, also driven out on hazard_ctrl.state
//   OP_NOP     : opcode of the bubble the execute stage substitutes when
//                bubble_ex is asserted (mirrors the NOP entry in opcodes.vh)
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } hz_state_t;

    localparam logic [7:0] OP_NOP = 8'h00;

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write bitmap plus lookup muxes.
//   clk, rst           : clock, synchronous active-low reset (clears all bits)
//   set_en, set_rd     : mark set_rd busy at the next edge
//   clr_en, clr_rd     : writeback commit, clear clr_rd at the next edge
//   ra, rb, rd         : decode register addresses to look up
//   busy_mask          : full bitmap, bit i = write to Ri pending
//   busy_ra/rb/rd      : bitmap bit for each looked-up address
module hazard_scoreboard #(
    parameter int unsigned NREG = 16,
    parameter int unsigned AW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_rd,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_rd,
    input  logic [AW-1:0]   ra,
    input  logic [AW-1:0]   rb,
    input  logic [AW-1:0]   rd,
    output logic [NREG-1:0] busy_mask,
    output logic            busy_ra,
    output logic            busy_rb,
    output logic            busy_rd
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear is applied before set so a new writer of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign busy_mask = busy_q;
    assign busy_ra   = busy_q[ra];
    assign busy_rb   = busy_q[rb];
    assign busy_rd   = busy_q[rd];

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock controller for the 32-bit core.
//   clk, rst                      : clock, synchronous active-low reset
//   id_valid, id_ra, id_rb,
//   id_use_rb, id_rd, id_wr_en,
//   id_is_jump                    : decoded instruction in decode stage
//   wb_valid, wb_rd               : writeback commit this cycle
//   issue                         : decode instruction accepted into execute
//   stall_if, stall_id            : hold fetch / decode registers
//   bubble_ex                     : execute receives a NOP
//   flush_if                      : squash fetch/decode after a jump
//   busy_mask                     : scoreboard of pending writes
//   state                         : 00 RUN, 01 STALL, 10 FLUSH
//   err_stall                     : sticky watchdog, stall ran MAX_STALL cycles
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned NREG      = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned MAX_STALL = 15,
    parameter int unsigned FLUSH_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_ra,
    input  logic [AW-1:0]   id_rb,
    input  logic            id_use_rb,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_wr_en,
    input  logic            id_is_jump,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    output logic            issue,
    output logic            stall_if,
    output logic            stall_id,
    output logic            bubble_ex,
    output logic            flush_if,
    output logic [NREG-1:0] busy_mask,
    output logic [1:0]      state,
    output logic            err_stall
);

    localparam int unsigned SCW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam int unsigned FCW = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);

    hz_state_t      st_q;
    logic [SCW-1:0] stall_cnt;
    logic [SCW-1:0] stall_cnt_inc;
    logic [FCW-1:0] flush_cnt;
    logic           busy_ra, busy_rb, busy_rd;
    logic           hazard;
    logic           stall;

    hazard_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (issue & id_wr_en),
        .set_rd    (id_rd),
        .clr_en    (wb_valid),
        .clr_rd    (wb_rd),
        .ra        (id_ra),
        .rb        (id_rb),
        .rd        (id_rd),
        .busy_mask (busy_mask),
        .busy_ra   (busy_ra),
        .busy_rb   (busy_rb),
        .busy_rd   (busy_rd)
    );

    // The busy_rd term is the WAW interlock.
    assign hazard = id_valid & (busy_ra | (id_use_rb & busy_rb) | (id_wr_en & busy_rd));

    // RUN and STALL share one output decode; they differ only in the counter.
    always_comb begin
        issue     = 1'b0;
        stall     = 1'b0;
        bubble_ex = 1'b1;
        flush_if  = 1'b0;
        if (rst) begin
            if (st_q == ST_FLUSH) begin
                flush_if = 1'b1;
            end else if (id_valid) begin
                if (hazard) begin
                    stall = 1'b1;
                end else begin
                    issue     = 1'b1;
                    bubble_ex = 1'b0;
                end
            end
        end
    end

    assign stall_if = stall;
    assign stall_id = stall;
    assign state    = st_q;

    assign stall_cnt_inc = (stall_cnt == SCW'(MAX_STALL)) ? stall_cnt : stall_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q      <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
            err_stall <= 1'b0;
        end else begin
            stall_cnt <= stall ? stall_cnt_inc : '0;
            if (stall && (stall_cnt_inc == SCW'(MAX_STALL)))
                err_stall <= 1'b1;

            case (st_q)
                ST_FLUSH: begin
                    if (flush_cnt <= FCW'(1)) begin
                        st_q      <= ST_RUN;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    if (stall) begin
                        st_q <= ST_STALL;
                    end else if (issue && id_is_jump) begin
                        st_q      <= ST_FLUSH;
                        flush_cnt <= FCW'(FLUSH_CYC);
                    end else begin
                        st_q <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule
